// File: rtl/blink_arbiter.sv
// Round-robin sequencer for the shared status LED: grants one requester at a time and blinks its burst.
// Optional macro BLINK_ABORT_EN: the owner dropping req mid-service aborts the burst without a done pulse.
module blink_arbiter #(
    parameter int NREQ        = 4,
    parameter int HALF_PERIOD = 15000,
    parameter int DIV_W       = 21,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_count,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  led,
    output logic                  busy
);
    localparam int PW = $clog2(NREQ);
    localparam int unsigned NREQ_U = NREQ;
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t            state_q, state_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;

    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     win_next;
    logic [NREQ-1:0]   avail;
    logic [CNT_W-1:0]  cnt;
    int unsigned       idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        busy_d  = busy_q;
        grant_d = grant_q;
        done_d  = '0;
        div_d   = div_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;

        // A requester currently pulsing done is skipped so it can drop req first.
        avail = req & ~done_q;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            idx = (32'(ptr_q) + i) % NREQ_U;
            if (!found && avail[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_next = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        cnt      = req_count[32'(win)*CNT_W +: CNT_W];

        case (state_q)
            IDLE: begin
                if (found) begin
                    ptr_d = win_next;
                    if (cnt != '0) begin
                        grant_d = NREQ'(1) << win;
                        led_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ON;
                        rem_d   = cnt;
                        div_d   = RELOAD;
                        owner_d = win;
                    end else begin
                        done_d[win] = 1'b1;
                    end
                end
            end
            ON: begin
                if (div_q == '0) begin
                    led_d   = 1'b0;
                    state_d = OFF;
                    div_d   = RELOAD;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            OFF: begin
                if (div_q == '0) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q != CNT_W'(1)) begin
                        led_d   = 1'b1;
                        state_d = ON;
                        div_d   = RELOAD;
                    end else begin
                        state_d         = IDLE;
                        grant_d         = '0;
                        busy_d          = 1'b0;
                        done_d[owner_q] = 1'b1;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BLINK_ABORT_EN
        if (state_q != IDLE && !req[owner_q]) begin
            state_d = IDLE;
            led_d   = 1'b0;
            grant_d = '0;
            busy_d  = 1'b0;
            done_d  = '0;
            div_d   = '0;
            rem_d   = '0;
        end
`endif
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign led   = led_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_blink_arbiter.sv
// Directed bench for blink_arbiter with HALF_PERIOD=3, NREQ=4, CNT_W=4.
// Checks run #1 after each rising edge; define BLINK_ABORT_EN to exercise the abort path.
module tb_blink_arbiter;
    localparam int NREQ = 4;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] req_count = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  led;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    blink_arbiter #(
        .NREQ(NREQ),
        .HALF_PERIOD(3),
        .DIV_W(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_count(req_count),
        .grant(grant),
        .done(done),
        .led(led),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        logic [11:0] pat;
        pat = 12'b111000111000;
        do_reset();
        req_count = 16'h0002;
        req = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++; if (led !== pat[11-k]) begin errors++; $display("FAIL burst_led cycle %0d got %b want %b", k, led, pat[11-k]); end
            checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL burst_grant cycle %0d got %b want 0001", k, grant); end
            checks++; if (done !== 4'b0000) begin errors++; $display("FAIL burst_early_done cycle %0d got %b want 0000", k, done); end
        end
        req = 4'b0000;
        step();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL burst_done got %b want 0001", done); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL burst_grant_end got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end got %b want 0", busy); end
        step();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL burst_done_width got %b want 0000", done); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL burst_led_end got %b want 0", led); end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 3, 0, 1};
        logic [NREQ-1:0] oh;
        do_reset();
        req_count = 16'h1111;
        req = 4'b1011;
        for (int s = 0; s < 5; s++) begin
            oh = 4'b0001 << order[s];
            step();
            checks++; if (grant !== oh) begin errors++; $display("FAIL rr_grant svc %0d got %b want %b", s, grant, oh); end
            checks++; if (led !== 1'b1) begin errors++; $display("FAIL rr_led svc %0d got %b want 1", s, led); end
            for (int k = 0; k < 5; k++) step();
            checks++; if (grant !== oh) begin errors++; $display("FAIL rr_grant_hold svc %0d got %b want %b", s, grant, oh); end
            step();
            checks++; if (done !== oh) begin errors++; $display("FAIL rr_done svc %0d got %b want %b", s, done, oh); end
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_grant_gap svc %0d got %b want 0000", s, grant); end
        end
        req = '0;
    endtask

    task automatic test_zero_count();
        do_reset();
        req_count = 16'h0000;
        req = 4'b0100;
        step();
        checks++; if (done !== 4'b0100) begin errors++; $display("FAIL zero_done got %b want 0100", done); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL zero_grant got %b want 0000", grant); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL zero_led got %b want 0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy); end
        req = 4'b0000;
        step();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL zero_done_width got %b want 0000", done); end
    endtask

    task automatic test_done_mask();
        do_reset();
        req_count = 16'h0001;
        req = 4'b0001;
        for (int k = 0; k < 7; k++) step();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL mask_done got %b want 0001", done); end
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mask_no_regrant got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL mask_done_clear got %b want 0000", done); end
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mask_regrant got %b want 0001", grant); end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_count = 16'h0200;
        req = 4'b0100;
        for (int k = 0; k < 8; k++) step();
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL mid_second_on got %b want 1", led); end
        rst_n = 1'b0;
        step();
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL mid_led got %b want 0", led); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL mid_done got %b want 0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        rst_n = 1'b1;
        req_count = 16'h1001;
        req = 4'b1001;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_ptr_reset got %b want 0001", grant); end
        req = '0;
    endtask

    task automatic test_abort();
        do_reset();
        req_count = 16'h0030;
        req = 4'b0010;
        for (int k = 0; k < 4; k++) step();
        req = 4'b0000;
`ifdef BLINK_ABORT_EN
        step();
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL abort_led got %b want 0", led); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++; if (done !== 4'b0000) begin errors++; $display("FAIL abort_no_done cycle %0d got %b want 0000", k, done); end
        end
`else
        for (int k = 4; k < 18; k++) begin
            step();
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL noabort_grant cycle %0d got %b want 0010", k, grant); end
        end
        step();
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL noabort_done got %b want 0010", done); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL noabort_grant_end got %b want 0000", grant); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_zero_count();
        test_done_mask();
        test_reset_mid();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
